// File: rtl/pkt_send_arbiter_pkg.sv
// Shared flit definitions for the packet send arbiter: data width, packet length,
// flit-type encodings and the type-extract helper.
`ifndef DW
`define DW 18
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

package pkt_send_arbiter_pkg;
   localparam int DW          = `DW;
   localparam int PKT_LEN_DEF = `PKT_LEN;

   localparam logic [1:0] FLIT_HEAD = `HEAD;
   localparam logic [1:0] FLIT_BODY = `BODY;
   localparam logic [1:0] FLIT_TAIL = `TAIL;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } arb_state_e;

   function automatic logic [1:0] flit_type(input logic [DW-1:0] flit);
      return flit[DW-1:DW-2];
   endfunction
endpackage

// File: rtl/pkt_send_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo N.
module pkt_send_arbiter_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);
   always_comb begin : p_pick
      int j;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end
endmodule

// File: rtl/pkt_send_arbiter.sv
// Packet-atomic round-robin arbiter sharing one credit-controlled link between N_SRC send FIFOs.
// Optional per-source packet counters and protocol-error flag under PKT_SEND_ARB_STATS_EN.
module pkt_send_arbiter
   import pkt_send_arbiter_pkg::*;
#(
   parameter int N_SRC   = 2,
   parameter int CNT_W   = 8,
   parameter int CREDITS = 16,
   parameter int PKT_LEN = PKT_LEN_DEF
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_SRC-1:0]         src_valid,
   input  logic [N_SRC*DW-1:0]      src_data,
   input  logic [N_SRC*CNT_W-1:0]   src_cnt,
   output logic [N_SRC-1:0]         src_read,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   input  logic                     out_ready,
   input  logic                     credit_upd,
   output logic [$clog2(N_SRC)-1:0] grant_id,
   output logic                     busy
`ifdef PKT_SEND_ARB_STATS_EN
   ,
   output logic [N_SRC*16-1:0]      pkt_sent,
   output logic                     proto_err
`endif
);
   localparam int IW = $clog2(N_SRC);
   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0]    CRED_MAX = CW'(CREDITS);
   localparam logic [CW-1:0]    CRED_PKT = CW'(PKT_LEN);
   localparam logic [CNT_W-1:0] CNT_PKT  = CNT_W'(PKT_LEN);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] rr_q, rr_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          busy_q, busy_d;

   logic [N_SRC-1:0] head_full;
   logic [N_SRC-1:0] eligible;
   logic             credit_ok;
   logic [IW-1:0]    pick_idx;
   logic             pick_found;
   logic             handshake;
   logic             tail_hs;

   assign credit_ok = (credit_q >= CRED_PKT);

   // A source qualifies only when its whole packet is resident and the link can absorb it.
   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_elig
         assign head_full[gi] = src_valid[gi] & (src_cnt[gi*CNT_W +: CNT_W] >= CNT_PKT);
         assign eligible[gi]  = head_full[gi] & credit_ok &
                                (flit_type(src_data[gi*DW +: DW]) == FLIT_HEAD);
      end
   endgenerate

   pkt_send_arbiter_rr_pick #(
      .N  (N_SRC),
      .IW (IW)
   ) u_rr_pick (
      .req   (eligible),
      .ptr   (rr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign out_data  = src_data[grant_q*DW +: DW];
   assign out_valid = (state_q == ST_SEND) & src_valid[grant_q] & (credit_q != '0);
   assign handshake = out_valid & out_ready;
   assign tail_hs   = handshake & (flit_type(out_data) == FLIT_TAIL);
   assign src_read  = handshake ? (N_SRC'(1) << grant_q) : '0;
   assign grant_id  = grant_q;
   assign busy      = busy_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      credit_d = credit_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tail_hs) begin
               state_d = ST_IDLE;
               rr_d    = (grant_q == IW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Return and spend in the same cycle cancel; returns beyond full depth are dropped.
      if (handshake && !credit_upd)
         credit_d = credit_q - 1'b1;
      else if (credit_upd && !handshake && credit_q != CRED_MAX)
         credit_d = credit_q + 1'b1;
      busy_d = (state_d == ST_SEND);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_q     <= '0;
         credit_q <= CRED_MAX;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         credit_q <= credit_d;
         busy_q   <= busy_d;
      end
   end

`ifdef PKT_SEND_ARB_STATS_EN
   logic [N_SRC*16-1:0] pkt_sent_q, pkt_sent_d;
   logic                proto_err_q, proto_err_d;
   logic [N_SRC-1:0]    bad_front;
   logic                overflow;

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_stats
         assign bad_front[gi] = head_full[gi] &
                                (flit_type(src_data[gi*DW +: DW]) != FLIT_HEAD);
         assign pkt_sent_d[gi*16 +: 16] = pkt_sent_q[gi*16 +: 16] +
                                          ((tail_hs && grant_q == IW'(gi)) ? 16'd1 : 16'd0);
      end
   endgenerate

   assign overflow    = credit_upd & ~handshake & (credit_q == CRED_MAX);
   assign proto_err_d = proto_err_q | overflow | ((state_q == ST_IDLE) & (|bad_front));
   assign pkt_sent    = pkt_sent_q;
   assign proto_err   = proto_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_sent_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         pkt_sent_q  <= pkt_sent_d;
         proto_err_q <= proto_err_d;
      end
   end
`endif
endmodule

// File: doc/pkt_send_arbiter.md
Name: pkt_send_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one network output link between N_SRC send buffers, e.g. the cast and gather send FIFOs of a network interface.
- Grants a source only when a complete packet is buffered and the downstream has credit for the whole packet.
- Holds the grant until the TAIL flit transfers, so packets are never interleaved on the link.
- Sits between the send FIFOs (FWFT, with occupancy count) and the router local input port.

Parameters:
- N_SRC, 2, number of requesting send buffers (2..8).
- CNT_W, 8, width of each source occupancy count.
- CREDITS, 16, downstream input buffer depth in flits; initial credit value.
- PKT_LEN, `PKT_LEN, flits per packet, HEAD..TAIL inclusive; must be <= CREDITS.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- src_valid  in  N_SRC  source FIFO non-empty (FWFT front valid)
- src_data  in  N_SRC*`DW  source FIFO front flits; source i at [i*`DW +: `DW]
- src_cnt  in  N_SRC*CNT_W  source FIFO occupancy
- src_read  out  N_SRC  pop strobe, one-hot or zero
- out_valid  out  1  flit valid to the router
- out_data  out  `DW  flit to the router
- out_ready  in  1  router accepts the flit
- credit_upd  in  1  downstream freed one flit slot (one pulse per flit)
- grant_id  out  $clog2(N_SRC)  current or last granted source
- busy  out  1  in SEND state

Behaviour:
- Flit type is out_data[`DW-1:`DW-2], encoded `HEAD / `BODY / `TAIL.
- eligible[i] = src_valid[i] & (type of src_data[i] == `HEAD) & (src_cnt[i] >= PKT_LEN) & (credit >= PKT_LEN).
- FSM states:
  - IDLE: if any eligible, pick the first eligible at or after rr_ptr (wrap modulo N_SRC), register grant_id, go to SEND.
  - SEND: out_valid = src_valid[grant_id] & (credit != 0); out_data = src_data[grant_id] (combinational mux); src_read[grant_id] = out_valid & out_ready.
  - SEND exit: on a handshake of a `TAIL flit, go to IDLE and set rr_ptr = grant_id+1 (wrap).
- Latency: eligibility is registered, so the HEAD flit is presented one cycle after eligibility is seen. There is one idle cycle between back-to-back packets (TAIL cycle, then the IDLE decision cycle).
- Credit counter, width $clog2(CREDITS+1):
  - Decrements on out_valid & out_ready; increments on credit_upd.
  - Both in the same cycle: value unchanged.
  - credit_upd at credit==CREDITS: value held at CREDITS (overflow ignored).
  - Decrement at 0 cannot occur, because out_valid is gated by credit != 0.
- Source runs dry mid-packet (src_valid low): out_valid deasserts, grant is held, no timeout.
- src_cnt counts the front flit, so cnt >= PKT_LEN guarantees the whole packet is resident.
- Outputs in IDLE: out_valid=0, src_read=0, busy=0; out_data = src_data[grant_id] (don't-care).
- Reset values: state IDLE, rr_ptr 0, grant_id 0, credit CREDITS, out_valid 0, src_read 0, busy 0.
- Reset mid-packet drops out_valid asynchronously. Recovery of the downstream partial packet is a system-level matter.

Optional Feature:
- Macro: PKT_SEND_ARB_STATS_EN.
- Defined:
  - Adds output pkt_sent (N_SRC*16): per-source packet counter, incremented on TAIL handshake, wraps at 2^16.
  - Adds output proto_err (1): sticky flag, set on credit overflow or on a non-HEAD flit seen while IDLE-eligible checks run with src_cnt>=PKT_LEN. Cleared only by reset.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared params package/header holds `DW, `PKT_LEN, flit-type encodings `HEAD/`BODY/`TAIL, and the flit-type extract helper.
- One sub-module: rr_pick, a combinational round-robin first-eligible finder from rr_ptr over an N_SRC request vector, returning index and a found flag.

Test Plan:
- Single source: src0 cnt=4, PKT_LEN=4, CREDITS=16 -> HEAD out one cycle after eligibility; 4 consecutive handshakes; credit 16->12; src_read[0] pulses 4 times; busy drops after TAIL.
- Both sources eligible continuously -> grants alternate 0,1,0,1; no interleaving; one bubble cycle between packets.
- Credit starvation: CREDITS=4, no credit_upd after the first packet -> second packet not granted. Pulse credit_upd 4 times -> grant within 2 cycles.
- Simultaneous credit_upd and handshake every cycle at credit=5 -> credit stays 5 for the whole packet.
- src_valid drops for 3 cycles mid-packet -> out_valid low for 3 cycles, grant_id unchanged, packet resumes.
- rstn asserted during a BODY flit -> out_valid=0 immediately; after release credit=CREDITS, rr_ptr=0. With STATS_EN, pkt_sent=0.
